// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for the pwm block: steps duty_cycle toward a
// commanded target, one update per PWM period boundary, clamped at the target.
module pwm_ramp_ctrl #(
    parameter logic [7:0] DUTY_INIT = 8'd0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    input  logic [7:0] cmd_hold,
    input  logic       abort,
    output logic [7:0] duty_cycle,
    output logic       busy,
    output logic       done,
    output logic       frame_start
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_duty;
    logic [7:0] r_target;
    logic [7:0] r_step;
    logic [7:0] r_hold;
    logic [7:0] r_wait_cnt;
    logic       r_done;

    state_t     w_state_nxt;
    logic [7:0] w_duty_nxt;
    logic [7:0] w_target_nxt;
    logic [7:0] w_step_nxt;
    logic [7:0] w_hold_nxt;
    logic [7:0] w_wait_nxt;
    logic       w_done_nxt;
    logic       w_boundary;
    logic       w_accept;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_step_duty;

    assign w_boundary  = (r_frame_cnt == 8'hFF);
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state == S_RAMP);
    assign w_accept    = cmd_valid & cmd_ready;
    assign frame_start = (r_frame_cnt == 8'h00);
    assign duty_cycle  = r_duty;
    assign done        = r_done;

    // Nine-bit sum/difference expose the carry/borrow so the clamp below
    // never lets the duty wrap past 255 or 0.
    assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
    assign w_diff = {1'b0, r_duty} - {1'b0, r_step};

    always_comb begin
        w_step_duty = r_target;
        if (r_step != 8'd0) begin
            if (r_target > r_duty) begin
                if (w_sum < {1'b0, r_target}) w_step_duty = w_sum[7:0];
            end else begin
                if (!w_diff[8] && (w_diff[7:0] > r_target)) w_step_duty = w_diff[7:0];
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no branch can infer a latch.
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target;
        w_step_nxt   = r_step;
        w_hold_nxt   = r_hold;
        w_wait_nxt   = r_wait_cnt;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_target_nxt = cmd_target;
                    w_step_nxt   = cmd_step;
                    w_hold_nxt   = cmd_hold;
                    if (cmd_target == r_duty) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RAMP;
                        w_wait_nxt  = 8'd0;
                    end
                end
            end
            S_RAMP: begin
                // Abort takes priority over a step landing in the same cycle.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_boundary) begin
                    if (r_wait_cnt != 8'd0) begin
                        w_wait_nxt = r_wait_cnt - 8'd1;
                    end else begin
                        w_duty_nxt = w_step_duty;
                        w_wait_nxt = r_hold;
                        if (w_step_duty == r_target) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 8'd0;
            r_duty      <= DUTY_INIT;
            r_target    <= 8'd0;
            r_step      <= 8'd0;
            r_hold      <= 8'd0;
            r_wait_cnt  <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_duty      <= w_duty_nxt;
            r_target    <= w_target_nxt;
            r_step      <= w_step_nxt;
            r_hold      <= w_hold_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_done      <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed and randomized commands checked every cycle
// against a schedule-based model (list of timed duty updates per ramp).
module tb_pwm_ramp_ctrl;

    localparam logic [7:0] DUTY_INIT = 8'd0;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_hold;
    logic       abort;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;
    logic       frame_start;

    pwm_ramp_ctrl #(.DUTY_INIT(DUTY_INIT)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done),
        .frame_start(frame_start)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int at_cyc;
        int val;
    } upd_t;

    upd_t sched[$];
    int   cyc;
    int   done_cyc;
    int   m_duty;
    bit   m_busy;
    bit   m_accepted;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int next_duty(input int d, input int s, input int t);
        if (s == 0) return t;
        if (t > d) return (d + s < t) ? d + s : t;
        return (d - s > t) ? d - s : t;
    endfunction

    // Whole ramp precomputed at accept time: boundary k gets update k.
    task automatic plan_ramp(input int t0, input int tgt, input int stp, input int hld);
        int f;
        int first;
        int d;
        int k;
        f     = t0 % 256;
        first = (f == 255) ? t0 + 256 : t0 + (255 - f);
        d     = m_duty;
        k     = 0;
        while (d != tgt) begin
            d = next_duty(d, stp, tgt);
            sched.push_back('{first + k * (hld + 1) * 256, d});
            k++;
        end
    endtask

    // One clock cycle: compare outputs, apply this cycle's inputs to the model, advance.
    task automatic cycle();
        bit was_busy;
        check("duty", duty_cycle, m_duty);
        check("busy", busy, m_busy);
        check("cmd_ready", cmd_ready, !m_busy);
        check("done", done, (cyc == done_cyc));
        check("frame_start", frame_start, (cyc % 256 == 0));
        m_accepted = 1'b0;
        if (reset) begin
            @(posedge clock_in);
            m_duty   = DUTY_INIT;
            m_busy   = 1'b0;
            done_cyc = -1;
            sched.delete();
            cyc = 0;
            @(negedge clock_in);
            return;
        end
        was_busy = m_busy;
        if (!was_busy && cmd_valid) begin
            m_accepted = 1'b1;
            if (cmd_target == m_duty[7:0]) begin
                done_cyc = cyc + 1;
            end else begin
                plan_ramp(cyc, cmd_target, cmd_step, cmd_hold);
                m_busy = 1'b1;
            end
        end else if (was_busy && abort) begin
            sched.delete();
            m_busy = 1'b0;
        end else if (was_busy && sched.size() > 0 && sched[0].at_cyc == cyc) begin
            m_duty = sched[0].val;
            void'(sched.pop_front());
            if (sched.size() == 0) begin
                m_busy   = 1'b0;
                done_cyc = cyc + 1;
            end
        end
        @(posedge clock_in);
        cyc++;
        @(negedge clock_in);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input int tgt, input int stp, input int hld);
        cmd_target = 8'(tgt);
        cmd_step   = 8'(stp);
        cmd_hold   = 8'(hld);
        cmd_valid  = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            cycle();
            if (m_accepted) break;
        end
        if (!m_accepted) check("accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && m_busy; i++) cycle();
        if (m_busy) check("idle_timeout", 32'd0, 32'd1);
        run(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int c0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_target = 8'd0;
        cmd_step   = 8'd0;
        cmd_hold   = 8'd0;
        cyc        = 0;
        done_cyc   = -1;
        m_duty     = DUTY_INIT;
        m_busy     = 1'b0;
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        reset = 1'b0;
        check("rst_duty", duty_cycle, DUTY_INIT);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_frame_start", frame_start, 1'b1);

        // Up-ramp accepted at frame 10: 4, 8, 12, 16.
        run(10);
        send(8'h10, 4, 0);
        wait_idle();
        check("up_final", duty_cycle, 8'h10);

        // Down-ramp clamped at 5, then a big up-step clamped at 255.
        send(5, 4, 0);
        wait_idle();
        check("down_final", duty_cycle, 8'd5);
        send(255, 200, 0);
        wait_idle();
        check("clamp_top", duty_cycle, 8'hFF);

        // Jump and no-op commands.
        send(8'h80, 0, 0);
        wait_idle();
        check("jump", duty_cycle, 8'h80);
        send(8'h80, 3, 0);
        check("noop_busy", busy, 1'b0);
        run(3);

        // Slow ramp with hold=2 while commands are offered and must be refused.
        send(0, 0, 0);
        wait_idle();
        send(3, 1, 2);
        cmd_valid  = 1'b1;
        cmd_target = 8'hAA;
        run(300);
        cmd_valid = 1'b0;
        wait_idle();
        check("hold_final", duty_cycle, 8'd3);

        // Abort in a boundary cycle after the first step; new command next cycle.
        send(8'hF0, 8'h10, 0);
        for (int i = 0; i < 1000 && m_duty == 3; i++) cycle();
        while (cyc % 256 != 255) cycle();
        v     = m_duty;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_hold", duty_cycle, v);
        check("abort_ready", cmd_ready, 1'b1);
        c0 = cyc;
        send(8'h20, 0, 0);
        check("abort_accept_cycle", cyc, c0 + 1);
        check("abort_new_busy", busy, 1'b1);
        wait_idle();

        // Reset in the middle of a ramp.
        send(8'hC0, 8'h08, 0);
        run(700);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_duty", duty_cycle, DUTY_INIT);
        check("mid_rst_frame_start", frame_start, 1'b1);
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        run(260);

        // Randomized commands with refused offers, idle aborts and rare mid-ramp aborts.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 20)) begin
                abort = ($urandom_range(0, 3) == 0);
                cycle();
            end
            abort = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) == 0) v = m_duty;
            else v = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) c0 = 0;
            else c0 = $urandom_range(32, 255);
            send(v, c0, $urandom_range(0, 1));
            for (int i = 0; i < 20000 && m_busy; i++) begin
                abort      = ($urandom_range(0, 1499) == 0);
                cmd_valid  = ($urandom_range(0, 7) == 0);
                cmd_target = 8'($urandom_range(0, 255));
                cmd_step   = 8'($urandom_range(32, 255));
                cmd_hold   = 8'($urandom_range(0, 1));
                cycle();
            end
            cmd_valid = 1'b0;
            abort     = 1'b0;
            run(2);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer that owns the 8-bit `duty_cycle` input of the `pwm` block and ramps it toward a commanded target in programmable steps. Duty changes land only on PWM period boundaries. A free-running 8-bit frame counter runs in lockstep with the `pwm` counter: both share `clock_in` and `reset` and wrap every 256 cycles, so there are no mid-period glitches. Commands arrive over a valid/ready handshake from the board-control logic, and completion is flagged with a one-cycle `done` pulse.

## Interface
- `DUTY_INIT`, default 8'd0: duty value loaded on reset.
- `clock_in`  in  1  system clock, shared with `pwm`.
- `reset`  in  1  synchronous, active-high; shared with `pwm`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_target`  in  8  final duty value.
- `cmd_step`  in  8  magnitude of change per step; 0 = jump straight to target.
- `cmd_hold`  in  8  extra PWM periods to wait between steps.
- `abort`  in  1  stop ramp, freeze current duty.
- `duty_cycle`  out  8  registered; wired to `pwm.duty_cycle`.
- `busy`  out  1  high in RAMP.
- `done`  out  1  one-cycle pulse on reaching target.
- `frame_start`  out  1  high when frame counter == 0.

## Operation
- Reset: every output is driven to its reset value:
  - `frame_cnt`=0, state=IDLE.
  - `duty_cycle`=DUTY_INIT, `busy`=0, `done`=0.
  - `cmd_ready`=1, `frame_start`=1.
  - Internal `wait_cnt`=0.
- Frame counter: increments by 1 every cycle and wraps 255→0 (8-bit natural wrap). It is never stalled.
- A boundary is any cycle in which `frame_cnt`==255.
- States:
  - IDLE: `cmd_ready`=1 and `busy`=0.
  - RAMP: `cmd_ready`=0 and `busy`=1.
- IDLE, accept (`cmd_valid`&`cmd_ready`):
  - Latch target, step and hold.
  - If target == current `duty_cycle`: stay IDLE and pulse `done` on the next cycle.
  - Otherwise: go to RAMP with `wait_cnt`=0.
- RAMP, boundary cycle with `wait_cnt`≠0: decrement `wait_cnt`.
- RAMP, boundary cycle with `wait_cnt`==0:
  - Step toward target using 9-bit arithmetic, clamped at target so there is no overshoot and no wrap past 0/255.
  - Upward: duty = min(duty+step, target). Downward: duty = max(duty−step, target).
  - step==0: duty = target.
  - Reload `wait_cnt` from hold.
  - If the new duty == target: go to IDLE on the same edge and pulse `done` in the next cycle.
- RAMP, non-boundary cycle: duty unchanged.
- Abort:
  - When `abort`=1 in RAMP: go to IDLE on the next edge, `duty_cycle` keeps its present value, no `done`.
  - Abort wins over a simultaneous boundary step.
  - `abort` in IDLE is ignored and does not block acceptance in that cycle.
- Commands in RAMP: `cmd_valid` is not accepted (`cmd_ready`=0). The requester holds the command until the block returns to IDLE.
- Reset mid-ramp: behaviour is identical to reset at power-up, and any ramp in progress is discarded.

## Timing
- `duty_cycle` changes only on the edge that ends a boundary cycle, so the new value is in effect for the whole following period (`frame_cnt` 0..255).
- First step occurs at the first boundary strictly after the acceptance cycle. An acceptance in a boundary cycle waits for the next boundary.
- Step spacing: hold+1 periods, i.e. (hold+1)*256 cycles.
- `done` is high for exactly 1 cycle, coinciding with `frame_cnt`==0, for ramps ending on a boundary.
- `cmd_ready` is combinational from state, so an accept is possible in the same cycle `done` is high.
- `frame_start` is combinational from `frame_cnt`.

## Test plan
- Reset, then target=0x10, step=4, hold=0, accepted at `frame_cnt`=10:
  - `duty_cycle` takes 4, 8, 12, 16 on the edges after the next four boundaries.
  - `done` pulses once, together with the last update's `frame_cnt`=0.
  - `busy` falls on that same edge.
- Down-ramp with clamp, from duty 16: target=5, step=4, hold=0 → 12, 8, 5, no value below 5. Then target=255, step=200 → 205, 255.
- Jump and no-op cases:
  - step=0 with target=0x80 → a single update to 0x80 at the first boundary.
  - target equal to current duty → `done` pulse on the cycle after accept, `busy` never set.
- hold=2, step=1, 0→3: updates spaced exactly 768 cycles apart. `cmd_valid` pulsed during RAMP is never accepted and `cmd_ready` stays 0.
- Abort: `abort` asserted in a boundary cycle mid-ramp → duty holds its pre-boundary value, no `done`, and a new command is accepted on the following cycle.
- Reset asserted mid-ramp → next cycle shows `duty_cycle`=DUTY_INIT, `frame_cnt`=0, `frame_start`=1, `cmd_ready`=1, `busy`=0.
